// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: next-state modes, condition sources,
// well-known microstates and the STRB start states produced by the encoder.
package microseq_pkg;

    typedef enum logic [2:0] {
        N_ENCODE    = 3'b000,
        N_INIT      = 3'b001,
        N_CR        = 3'b010,
        N_INCR      = 3'b011,
        N_C_ENC_CR  = 3'b100,
        N_C_CR_INCR = 3'b101,
        N_C_CR_ENC  = 3'b110,
        N_RESERVED  = 3'b111
    } n_mode_e;

    typedef enum logic [1:0] {
        S_MOC   = 2'b00,
        S_COND  = 2'b01,
        S_IR_L  = 2'b10,
        S_ZERO  = 2'b11
    } s_src_e;

    localparam int INIT_STATE  = 0;
    localparam int FETCH_STATE = 1;
    localparam int TRAP_STATE  = 5;

    // STRB start states, named by indexing (PRE/POST) and offset kind (I bit).
    localparam int STRB_PRE_IMM    = 20;
    localparam int STRB_PRE_REG    = 24;
    localparam int STRB_PRE_WB_IMM = 28;
    localparam int STRB_PRE_WB_REG = 32;
    localparam int STRB_POST_IMM   = 36;
    localparam int STRB_POST_REG   = 40;

    function automatic logic is_strb(input logic [31:0] ir);
        return (ir[27:26] == 2'b01) && !ir[20] && ir[22];
    endfunction

endpackage

// File: rtl/instruction_encoder.sv
// Combinational decode of the instruction register into a microprogram start
// state; only single data transfer store-byte is recognised.
module instruction_encoder
    import microseq_pkg::*;
#(
    parameter int STATE_W         = 10,
    parameter int FETCH_STATE_DEF = microseq_pkg::FETCH_STATE
) (
    input  logic [31:0]        ir_i,
    output logic [STATE_W-1:0] start_state_o,
    output logic               recognised_o
);

    logic immBit;
    logic preBit;
    logic wbBit;

    assign immBit = ir_i[25];
    assign preBit = ir_i[24];
    assign wbBit  = ir_i[21];

    // Post-indexed forms always write back, so W is a don't-care when P=0.
    always_comb begin
        recognised_o  = is_strb(ir_i);
        start_state_o = STATE_W'(FETCH_STATE_DEF);
        if (recognised_o) begin
            if (!preBit) begin
                start_state_o = immBit ? STATE_W'(STRB_POST_REG)
                                       : STATE_W'(STRB_POST_IMM);
            end else if (!wbBit) begin
                start_state_o = immBit ? STATE_W'(STRB_PRE_REG)
                                       : STATE_W'(STRB_PRE_IMM);
            end else begin
                start_state_o = immBit ? STATE_W'(STRB_PRE_WB_REG)
                                       : STATE_W'(STRB_PRE_WB_IMM);
            end
        end
    end

    logic unused_ir;
    assign unused_ir = ^{ir_i[31:28], ir_i[23], ir_i[19:0]};

endmodule

// File: rtl/microsequencer.sv
// Next-state selection and state/incrementer registers of the microprogrammed
// control unit. Define MICROSEQ_ILLEGAL_TRAP_EN to enable the illegal-instruction trap.
module microsequencer
    import microseq_pkg::*;
#(
    parameter int STATE_W     = 10,
    parameter int CR_W        = 6,
    parameter int INIT_STATE  = microseq_pkg::INIT_STATE,
    parameter int FETCH_STATE = microseq_pkg::FETCH_STATE,
    parameter int TRAP_STATE  = microseq_pkg::TRAP_STATE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         n,
    input  logic               inv,
    input  logic [1:0]         s,
    input  logic [CR_W-1:0]    cr,
    input  logic [31:0]        ir,
    input  logic               moc,
    input  logic               cond_true,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] incr_q, incr_d;
    logic [STATE_W-1:0] encStart;
    logic [STATE_W-1:0] encState;
    logic [STATE_W-1:0] crState;
    logic [STATE_W-1:0] modeState;
    logic               encRecognised;
    logic               condSel;
    logic               cond;
    logic               trapHold;
    n_mode_e            mode;
    s_src_e             src;

    instruction_encoder #(
        .STATE_W         (STATE_W),
        .FETCH_STATE_DEF (FETCH_STATE)
    ) u_encoder (
        .ir_i          (ir),
        .start_state_o (encStart),
        .recognised_o  (encRecognised)
    );

    assign mode    = n_mode_e'(n);
    assign src     = s_src_e'(s);
    assign crState = STATE_W'(cr);

    always_comb begin
        condSel = 1'b0;
        case (src)
            S_MOC:   condSel = moc;
            S_COND:  condSel = cond_true;
            S_IR_L:  condSel = ir[20];
            default: condSel = 1'b0;
        endcase
    end

    assign cond = condSel ^ inv;

`ifdef MICROSEQ_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign encState = encRecognised ? encStart : STATE_W'(TRAP_STATE);
    assign trapHold = (state_q == STATE_W'(TRAP_STATE));

    always_comb begin
        illegal_d = illegal_q;
        if (state_d == STATE_W'(TRAP_STATE)) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign encState = encStart;
    assign trapHold = 1'b0;
    assign illegal  = 1'b0;

    logic unused_trap;
    assign unused_trap = encRecognised ^ (TRAP_STATE != 0);
`endif

    // Unused mode codes fall back to Init so the sequencer never wanders.
    always_comb begin
        modeState = STATE_W'(INIT_STATE);
        case (mode)
            N_ENCODE:    modeState = encState;
            N_INIT:      modeState = STATE_W'(INIT_STATE);
            N_CR:        modeState = crState;
            N_INCR:      modeState = incr_q;
            N_C_ENC_CR:  modeState = cond ? encState : crState;
            N_C_CR_INCR: modeState = cond ? crState : incr_q;
            N_C_CR_ENC:  modeState = cond ? crState : encState;
            default:     modeState = STATE_W'(INIT_STATE);
        endcase
        state_d = trapHold ? state_q : modeState;
        incr_d  = state_d + STATE_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_W'(INIT_STATE);
            incr_q  <= STATE_W'(INIT_STATE + 1);
        end else begin
            state_q <= state_d;
            incr_q  <= incr_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for the microsequencer; expectations are queued at drive time
// and compared just after the following rising edge.
module tb_microsequencer;

    logic        clk;
    logic        reset_n;
    logic [2:0]  n;
    logic        inv;
    logic [1:0]  s;
    logic [5:0]  cr;
    logic [31:0] ir;
    logic        moc;
    logic        cond_true;
    logic [9:0]  state;
    logic        illegal;

    typedef struct {
        logic [9:0] st;
        logic       ill;
        string      tag;
    } exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    logic expIllegal  = 1'b0;
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP_BUILD = 1'b1;
`else
    localparam bit TRAP_BUILD = 1'b0;
`endif

    microsequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .n         (n),
        .inv       (inv),
        .s         (s),
        .cr        (cr),
        .ir        (ir),
        .moc       (moc),
        .cond_true (cond_true),
        .state     (state),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one control word at the falling edge and queue the state expected after the next rising edge.
    task automatic applyStimulus(input logic [2:0] nV, input logic invV, input logic [1:0] sV,
                                 input logic [5:0] crV, input logic [31:0] irV,
                                 input logic mocV, input logic ctV,
                                 input logic [9:0] expState, input string tag);
        exp_t e;
        @(negedge clk);
        n = nV; inv = invV; s = sV; cr = crV; ir = irV; moc = mocV; cond_true = ctV;
        e.st  = expState;
        e.ill = expIllegal;
        e.tag = tag;
        expQ.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.tag, ".state"}, 32'(state), 32'(e.st));
            checkOutput({e.tag, ".illegal"}, 32'(illegal), 32'(e.ill));
        end
    end

    initial begin
        logic [31:0] strbIr[6];
        logic [9:0]  strbExp[6];
        strbIr  = '{32'hE5C10004, 32'hE7C10002, 32'hE5E10004,
                    32'hE7E10002, 32'hE4C10004, 32'hE6C10002};
        strbExp = '{10'd20, 10'd24, 10'd28, 10'd32, 10'd36, 10'd40};

        reset_n = 1'b0;
        n = 3'b001; inv = 1'b0; s = 2'b00; cr = '0; ir = '0; moc = 1'b0; cond_true = 1'b0;
        #3;
        checkOutput("reset.state", 32'(state), 32'd0);
        checkOutput("reset.illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(3'b011, 0, 2'b00, 6'd0, 32'h0, 0, 0, 10'd1, "inc_first");
        for (int i = 2; i <= 1022; i++) begin
            applyStimulus(3'b011, 0, 2'b00, 6'd0, 32'h0, 0, 0, 10'(i), "inc_run");
        end
        applyStimulus(3'b011, 0, 2'b00, 6'd0, 32'h0, 0, 0, 10'd1023, "inc_1023");
        applyStimulus(3'b011, 0, 2'b00, 6'd0, 32'h0, 0, 0, 10'd0, "inc_wrap");
        applyStimulus(3'b011, 0, 2'b00, 6'd0, 32'h0, 0, 0, 10'd1, "inc_after_wrap");

        applyStimulus(3'b010, 0, 2'b00, 6'd3, 32'h0, 0, 0, 10'd3, "cr_load3");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b101, 1, 2'b00, 6'd3, 32'h0, 0, 0, 10'd3, "moc_wait");
        end
        applyStimulus(3'b101, 1, 2'b00, 6'd3, 32'h0, 1, 0, 10'd4, "moc_release");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b100, 0, 2'b01, 6'd9, strbIr[i], 0, 1, strbExp[i], "strb_decode");
        end
        applyStimulus(3'b100, 0, 2'b01, 6'd1, strbIr[0], 0, 0, 10'd1, "cond_false_cr");
        applyStimulus(3'b000, 0, 2'b00, 6'd0, strbIr[3], 0, 0, 10'd32, "n000_strb");
        applyStimulus(3'b110, 0, 2'b10, 6'd17, 32'hE5D10004, 0, 0, 10'd17, "n110_irL_cr");
        applyStimulus(3'b110, 1, 2'b10, 6'd17, strbIr[5], 0, 0, 10'd17, "n110_inv_cr");
        applyStimulus(3'b110, 0, 2'b11, 6'd17, strbIr[4], 1, 1, 10'd36, "n110_zero_enc");
        applyStimulus(3'b101, 0, 2'b11, 6'd50, 32'h0, 1, 1, 10'd37, "n101_zero_inc");
        applyStimulus(3'b111, 0, 2'b00, 6'd9, 32'h0, 0, 0, 10'd0, "reserved_n111");
        applyStimulus(3'b010, 0, 2'b00, 6'd37, 32'h0, 0, 0, 10'd37, "cr_load37");
        applyStimulus(3'b001, 0, 2'b00, 6'd9, 32'h0, 0, 0, 10'd0, "init_n001");
        applyStimulus(3'b010, 0, 2'b00, 6'd37, 32'h0, 0, 0, 10'd37, "cr_load37b");

        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset.state", 32'(state), 32'd0);
        checkOutput("midreset.illegal", 32'(illegal), 32'd0);
        n = 3'b011;
        repeat (2) @(negedge clk);
        checkOutput("reset_held.state", 32'(state), 32'd0);
        reset_n = 1'b1;
        begin
            exp_t e;
            e.st = 10'd1; e.ill = 1'b0; e.tag = "post_reset_inc";
            expQ.push_back(e);
        end

        if (TRAP_BUILD) begin
            expIllegal = 1'b1;
            applyStimulus(3'b000, 0, 2'b00, 6'd0, 32'hE0810002, 0, 0, 10'd5, "add_trap");
            for (int i = 0; i < 10; i++) begin
                applyStimulus(3'b011, 0, 2'b00, 6'd0, 32'h0, 0, 0, 10'd5, "trap_hold");
            end
        end else begin
            applyStimulus(3'b000, 0, 2'b00, 6'd0, 32'hE0810002, 0, 0, 10'd1, "add_fetch");
            applyStimulus(3'b011, 0, 2'b00, 6'd0, 32'h0, 0, 0, 10'd2, "add_then_inc");
        end

        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("final_reset.state", 32'(state), 32'd0);
        checkOutput("final_reset.illegal", 32'(illegal), 32'd0);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state logic and state register of the microprogrammed control unit. Each cycle it selects the next microstate from one of four sources: the decode encoder, the control word's CR constant, the incrementer, or the Init constant. The selection is driven by the N/INV/S fields of the current control word and the status inputs. It registers the chosen state and drives it to the microstore's `next_state` input. The microstore's control word feeds back combinationally into this block.

## Interface
Parameters:
- `STATE_W`, 10, microstate address width.
- `CR_W`, 6, width of control word CR field.
- `INIT_STATE`, 0, reset/Init microstate.
- `FETCH_STATE`, 1, first fetch microstate.
- `TRAP_STATE`, 5, illegal-instruction trap microstate (used only with trap build).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `n`  in  3  control word N2..N0, next-state mode.
- `inv`  in  1  control word INV, condition inversion.
- `s`  in  2  control word S1..S0, condition source select.
- `cr`  in  `CR_W`  control word CR5..CR0, constant target state.
- `ir`  in  32  instruction register contents.
- `moc`  in  1  memory operation complete.
- `cond_true`  in  1  instruction condition-tester result.
- `state`  out  `STATE_W`  registered microstate, to microstore `next_state`.
- `illegal`  out  1  sticky illegal-instruction flag; constant 0 without trap build.

## Operation
- Condition `c` is `sel ^ inv`, where `sel` is selected by `s`:
  - 00: `moc`.
  - 01: `cond_true`.
  - 10: `ir[20]`.
  - 11: 0.
- Next state by `n`:
  - 000: encoder output.
  - 001: `INIT_STATE`.
  - 010: CR.
  - 011: incrementer.
  - 100: c ? encoder : CR.
  - 101: c ? CR : incrementer.
  - 110: c ? CR : encoder.
  - 111: `INIT_STATE` (reserved).
- CR is zero-extended to `STATE_W`.
- Incrementer register loads (next state + 1) mod 2^`STATE_W` on the same edge as `state`, so it always holds `state`+1; 1023 wraps to 0.
- Encoder is combinational on `ir`. Recognised class is single data transfer store byte: `ir[27:26]`=01, L=`ir[20]`=0, B=`ir[22]`=1. Start states:
  - I=`ir[25]`=0, P=1, W=0 → 20; I=1, P=1, W=0 → 24.
  - I=0, P=1, W=1 → 28; I=1, P=1, W=1 → 32.
  - I=0, P=0 → 36; I=1, P=0 → 40.
  - P=0 ignores W.
- Any other `ir` → `FETCH_STATE` (default build).
- The MOC wait loop is expressed as `n`=101, `inv`=1, `s`=00, CR=self. The block holds the state until `moc` rises, then increments.

## Timing
- Reset (async assert): `state`=`INIT_STATE`, incrementer=`INIT_STATE`+1, `illegal`=0, immediately and independent of `clk`.
- Reset mid-sequence aborts any microsequence, including a MOC wait. The first rising edge after deassertion evaluates the Init control word.
- One microstate per cycle. `state` changes only on a rising edge. The next-state path is combinational from inputs sampled at that edge.
- Inputs must be stable at the edge. `moc` is sampled, not edge-detected: a one-cycle `moc` pulse coinciding with the wait state releases it.
- No X propagation: unknown `n`/`s` codes are fully decoded as specified above.

## Configuration
- `MICROSEQ_ILLEGAL_TRAP_EN` defined:
  - Unrecognised `ir` selects `TRAP_STATE` instead of `FETCH_STATE`.
  - On the edge that loads `TRAP_STATE`, `illegal` sets and stays 1 until reset.
  - While `state`==`TRAP_STATE`, `state` holds regardless of control word.
- Not defined: no trap logic, `illegal` tied 0, unrecognised `ir` → `FETCH_STATE`.

## Structure
- `microseq_pkg` holds:
  - N-mode codes and S-source codes.
  - `INIT_STATE`, `FETCH_STATE`, `TRAP_STATE`.
  - STRB start-state constants 20/24/28/32/36/40.
- Sub-module `instruction_encoder`: combinational `ir` → start state plus `recognised` bit. The sequencer top holds the muxes, condition logic, state and incrementer registers, and trap flag.

## Test plan
- Reset: `reset_n`=0 mid-run at state 37 → `state`=0 and `illegal`=0 asynchronously. After release, with `n`=011, next edge → 1.
- Increment and wrap: force `n`=011 from state 1022 → 1023 → 0.
- MOC wait: state 3 with `n`=101, `inv`=1, `s`=00, `cr`=3, `moc`=0 for 4 cycles → holds 3. `moc`=1 → 4.
- Decode, all six STRB forms. With `n`=100, `s`=01, `cond_true`=1:
  - `ir`=0xE5C10004 → 20.
  - `ir`=0xE7C10002 → 24.
  - `ir`=0xE5E10004 → 28.
  - `ir`=0xE7E10002 → 32.
  - `ir`=0xE4C10004 → 36.
  - `ir`=0xE6C10002 → 40.
  - `cond_true`=0 with `cr`=1 → 1.
- Unrecognised `ir`=0xE0810002 (ADD) via `n`=000:
  - Default build → 1, `illegal`=0.
  - Trap build → 5, `illegal`=1, state holds 5 for 10 cycles with `n`=011.
- Reserved `n`=111 from any state → 0.
